cordic_host_ctrl: RTL and testbench
===================================

Name: cordic_host_ctrl

Overview:
- Host-side initiator for the iterative CORDIC cosine core; it drives the core's start/dataa/clk_en and consumes its done/result.
- Accepts IEEE-754 single-precision angles on a valid/ready stream.
- Converts each angle to signed Q1.20 with a serial aligner, issues one core operation, waits for done, and returns the 32-bit float result on a valid/ready stream.
- Replaces the unused combinational float-to-fixed path in front of the core.

Parameters:
- FIX_W, 21: fixed-point word width sent to the core.
- FRAC_W, 20: fractional bits in core operand (Q1.20).
- CORE_TIMEOUT, 64: maximum cycles in WAIT before the operation is aborted.

Ports:
- clock  in  1  system clock
- aclr_n  in  1  asynchronous active-low reset
- in_valid  in  1  angle operand valid
- in_ready  out  1  operand accepted when in_valid&in_ready
- in_data  in  32  IEEE-754 angle in radians
- core_clk_en  out  1  clock enable to core
- core_start  out  1  one-cycle start pulse to core
- core_dataa  out  FIX_W  Q1.20 operand to core
- core_done  in  1  core completion
- core_result  in  32  core float result
- out_valid  out  1  result valid
- out_ready  in  1  result accepted when out_valid&out_ready
- out_data  out  32  float result
- out_err  out  1  range error or timeout for this result

Behaviour:
- Interface: one clock (clock); reset aclr_n is asynchronous, active-low.
- Reset values: state=IDLE, in_ready=1, core_clk_en=0, core_start=0, core_dataa=0, out_valid=0, out_data=0, out_err=0, all counters 0.
- States: IDLE, ALIGN, ISSUE, WAIT, RESP.
- IDLE:
  - in_ready=1 only in this state.
  - On handshake, register the operand. Sign is discarded (cosine is even).
  - Decode e=in_data[30:23] and mant={1,in_data[22:0]}.
  - e=0 (zero/denormal) or e<107: operand=0, err=0, next state ISSUE.
  - e>=127 (|x|>=1, Inf, NaN): operand=21'h0FFFFF (saturate), err=1, next state ISSUE.
  - Otherwise: S=130-e (range 4..23), shift register=mant, next state ALIGN.
- ALIGN:
  - Logical right shift by 1 and decrement the counter each cycle, for exactly S cycles.
  - Result is truncated. The low FIX_W bits become the operand; the sign bit is always 0.
  - Then go to ISSUE.
- ISSUE (1 cycle):
  - core_start=1, core_clk_en=1, core_dataa=operand.
  - core_done is ignored in this cycle.
- WAIT:
  - core_clk_en=1, core_start=0, core_dataa held stable.
  - Timeout counter increments each cycle.
  - On core_done=1: capture core_result into out_data, out_err=err, go to RESP.
  - Timeout has priority over a same-cycle core_done. If counter reaches CORE_TIMEOUT without done: out_data=32'h7FC00000, out_err=1, go to RESP.
  - Nominal core done arrives 16 cycles after ISSUE.
- RESP:
  - out_valid=1, core_clk_en=0.
  - out_data and out_err stay stable until out_ready.
  - On the out_ready cycle, go to IDLE. out_valid drops next cycle; in_ready rises next cycle (no same-cycle bypass).
- Throughput: one operation in flight. Latency from input handshake to out_valid = 1 + S + 1 + 16 + 1 cycles (S=0 for zero/saturate paths).
- in_valid while busy: ignored (in_ready=0). in_data need not be held after handshake.
- core_done outside WAIT: ignored.
- Reset asserted mid-operation: immediate return to reset values. The pending operation is lost and no output is produced.

Decomposition:
- Package cordic_pkg:
  - FIX_W, FRAC_W, EXP_BIAS=127.
  - Alignment constant 130 (=EXP_BIAS+3).
  - Minimum exponent 107.
  - FIX_SAT=21'h0FFFFF, FP_QNAN=32'h7FC00000.
  - State enum type.
- Sub-module fp_align_serial:
  - Does exponent decode, the special-case classification, and the S-cycle shifter.
  - Handshake: load/busy/valid. Outputs operand and err.
- The FSM, timeout counter and result capture stay in cordic_host_ctrl.

Test Plan:
- in_data=32'h3F000000 (0.5), core stub done 16 cycles after start returning 32'h3F60A940 → core_dataa=21'h080000; 4 ALIGN cycles; out_data=32'h3F60A940, out_err=0; out_valid 23 cycles after handshake.
- in_data=32'hBE800000 (-0.25) → core_dataa=21'h040000 (sign dropped), S=5, out_err=0.
- in_data=32'h3F800000 (1.0), then 32'h7FC00000 (NaN) → no ALIGN cycles, core_dataa=21'h0FFFFF, out_err=1 for both.
- in_data=32'h33800000 (2^-24) and 32'h00000000 → core_dataa=0, out_err=0; core still started once per operand.
- core stub never asserts done → out_valid after CORE_TIMEOUT WAIT cycles, out_data=32'h7FC00000, out_err=1; next operand accepted normally.
- out_ready held low 10 cycles in RESP → out_data stable, in_ready=0. aclr_n pulsed low during ALIGN → core_start never pulses, out_valid stays 0, in_ready=1 after release.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and state type for the CORDIC host controller.
// Float-to-Q1.20 alignment limits and special result encodings.
package cordic_pkg;

    localparam int FIX_W  = 21;
    localparam int FRAC_W = 20;

    localparam logic [7:0] EXP_BIAS = 8'd127;
    localparam logic [7:0] ALIGN_K  = EXP_BIAS + 8'd3;
    localparam logic [7:0] MIN_EXP  = 8'd107;

    localparam logic [FIX_W-1:0] FIX_SAT = 21'h0FFFFF;
    localparam logic [31:0]      FP_QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/fp_align_serial.sv
// Serial IEEE-754 single to unsigned Q1.20 aligner.
// Classifies the exponent on load, then shifts right once per cycle.
module fp_align_serial
    import cordic_pkg::*;
#(
    parameter int OP_W    = 21,
    parameter int OP_FRAC = 20
) (
    input  logic            clock,
    input  logic            aclr_n,
    input  logic            load,
    input  logic [31:0]     data,
    output logic            busy,
    output logic            valid,
    output logic [OP_W-1:0] operand,
    output logic            err
);

    logic [7:0]  e;
    logic [23:0] mant;
    logic [23:0] sh;
    logic [4:0]  cnt;
    logic [4:0]  s_amt;
    logic        zero;
    logic        sat;
    logic        unused_sign;

    // cosine is even, so the sign never matters
    assign unused_sign = data[31];

    assign e     = data[30:23];
    assign mant  = {1'b1, data[22:0]};
    assign zero  = (e < MIN_EXP);
    assign sat   = (e >= EXP_BIAS);
    assign s_amt = 5'(ALIGN_K - e);

    assign busy    = (cnt != 5'd0);
    assign valid   = (busy && cnt == 5'd1) || (load && (zero || sat));
    assign operand = {1'b0, sh[OP_FRAC-1:0]};

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            sh  <= '0;
            cnt <= '0;
            err <= 1'b0;
        end else if (load) begin
            err <= sat;
            cnt <= '0;
            if (sat) begin
                sh <= 24'(FIX_SAT);
            end else if (zero) begin
                sh <= '0;
            end else begin
                sh  <= mant;
                cnt <= s_amt;
            end
        end else if (busy) begin
            sh  <= sh >> 1;
            cnt <= cnt - 5'd1;
        end
    end

endmodule

// File: rtl/cordic_host_ctrl.sv
// Host-side initiator for the iterative CORDIC cosine core.
// Aligns one float angle, runs the core once, returns its float result.
module cordic_host_ctrl #(
    parameter int FIX_W        = 21,
    parameter int FRAC_W       = 20,
    parameter int CORE_TIMEOUT = 64
) (
    input  logic             clock,
    input  logic             aclr_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             core_clk_en,
    output logic             core_start,
    output logic [FIX_W-1:0] core_dataa,
    input  logic             core_done,
    input  logic [31:0]      core_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_err
);

    localparam int TW = $clog2(CORE_TIMEOUT + 1);

    cordic_pkg::state_t state;
    cordic_pkg::state_t next;

    logic          load;
    logic          a_busy;
    logic          a_valid;
    logic          a_err;
    logic          timeout;
    logic [TW-1:0] tcnt;

    fp_align_serial #(
        .OP_W    (FIX_W),
        .OP_FRAC (FRAC_W)
    ) u_align (
        .clock   (clock),
        .aclr_n  (aclr_n),
        .load    (load),
        .data    (in_data),
        .busy    (a_busy),
        .valid   (a_valid),
        .operand (core_dataa),
        .err     (a_err)
    );

    assign in_ready    = (state == cordic_pkg::IDLE);
    assign core_start  = (state == cordic_pkg::ISSUE);
    assign core_clk_en = (state == cordic_pkg::ISSUE) ||
                         (state == cordic_pkg::WAIT);
    assign out_valid   = (state == cordic_pkg::RESP);
    assign timeout     = (tcnt == TW'(CORE_TIMEOUT - 1));

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state <= cordic_pkg::IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        load = 1'b0;
        unique case (state)
            cordic_pkg::IDLE: begin
                if (in_valid) begin
                    load = 1'b1;
                    next = a_valid ? cordic_pkg::ISSUE
                                   : cordic_pkg::ALIGN;
                end
            end
            cordic_pkg::ALIGN: begin
                if (a_valid || !a_busy) next = cordic_pkg::ISSUE;
            end
            cordic_pkg::ISSUE: next = cordic_pkg::WAIT;
            cordic_pkg::WAIT: begin
                if (timeout || core_done) next = cordic_pkg::RESP;
            end
            cordic_pkg::RESP: begin
                if (out_ready) next = cordic_pkg::IDLE;
            end
            default: next = cordic_pkg::IDLE;
        endcase
    end

    // timeout wins over a done arriving in the same cycle
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            tcnt     <= '0;
            out_data <= '0;
            out_err  <= 1'b0;
        end else if (state == cordic_pkg::ISSUE) begin
            tcnt <= '0;
        end else if (state == cordic_pkg::WAIT) begin
            tcnt <= tcnt + 1'b1;
            if (timeout) begin
                out_data <= cordic_pkg::FP_QNAN;
                out_err  <= 1'b1;
            end else if (core_done) begin
                out_data <= core_result;
                out_err  <= a_err;
            end
        end
    end

endmodule

// File: tb/tb_cordic_host_ctrl.sv
// Bench for cordic_host_ctrl: core stub plus a real-arithmetic reference.
// Directed spec cases followed by randomized angles.
module tb_cordic_host_ctrl;

    logic        clock = 1'b0;
    logic        aclr_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        core_clk_en;
    logic        core_start;
    logic [20:0] core_dataa;
    logic        core_done = 1'b0;
    logic [31:0] core_result = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    int          stub_cnt = 0;
    int          starts = 0;
    bit          stub_en = 1'b1;
    logic [20:0] start_data = '0;

    cordic_host_ctrl dut (
        .clock       (clock),
        .aclr_n      (aclr_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .core_clk_en (core_clk_en),
        .core_start  (core_start),
        .core_dataa  (core_dataa),
        .core_done   (core_done),
        .core_result (core_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_err     (out_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // core stub: done pulses in the 16th cycle after the start cycle
    always @(negedge clock) begin
        core_done = 1'b0;
        if (stub_cnt > 0) begin
            stub_cnt--;
            if (stub_cnt == 0 && stub_en) core_done = 1'b1;
        end
        if (core_start) begin
            starts++;
            start_data = core_dataa;
            stub_cnt = 16;
            core_result = $urandom;
        end
    end

    function automatic void model(input logic [31:0] d,
                                  output logic [20:0] op,
                                  output bit err, output int s);
        int  e;
        real v;
        e   = int'(d[30:23]);
        op  = '0;
        err = 1'b0;
        s   = 0;
        if (e == 255) begin
            op  = 21'h0FFFFF;
            err = 1'b1;
        end else if (e != 0) begin
            v = real'({1'b1, d[22:0]}) * (2.0 ** (e - 150));
            if (v >= 1.0) begin
                op  = 21'h0FFFFF;
                err = 1'b1;
            end else if (v >= 2.0 ** (-20)) begin
                op = 21'($rtoi($floor(v * 1048576.0)));
                s  = 130 - e;
            end
        end
    endfunction

    task automatic run_op(input logic [31:0] d, input bit hang,
                          input int hold);
        logic [20:0] eop;
        bit          eerr;
        int          es;
        int          lat;
        int          al;
        int          n0;
        int          elat;
        logic [31:0] eres;
        logic [31:0] snap;
        bit          ok;
        model(d, eop, eerr, es);
        stub_en = !hang;
        n0 = starts;
        lat = 0;
        while (!in_ready && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        chk("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data = d;
        @(negedge clock);
        lat = 2;
        al = 0;
        while (lat < 200) begin
            if (out_valid) break;
            if (!in_ready && !core_clk_en) al++;
            in_valid = (lat < 5);
            in_data = $urandom;
            @(negedge clock);
            lat++;
        end
        in_valid = 1'b0;
        elat = hang ? es + 67 : es + 19;
        eres = hang ? 32'h7FC00000 : core_result;
        chk("latency", lat, elat);
        chk("align_cycles", al, es);
        chk("starts", starts - n0, 1);
        chk("core_dataa", 32'(start_data), 32'(eop));
        chk("out_data", out_data, eres);
        chk("out_err", 32'(out_err), 32'(hang | eerr));
        if (hold > 0) begin
            snap = out_data;
            ok = 1'b1;
            repeat (hold) begin
                @(negedge clock);
                if (!out_valid || in_ready || out_data !== snap) ok = 1'b0;
            end
            chk("hold_stable", 32'(ok), 32'd1);
        end
        out_ready = 1'b1;
        chk("no_bypass", 32'(in_ready), 32'd0);
        @(negedge clock);
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("ready_back", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  e;
        logic [31:0] d;
        int          n0;
        bit          bad;
        repeat (3) @(negedge clock);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_clk_en", 32'(core_clk_en), 32'd0);
        chk("rst_start", 32'(core_start), 32'd0);
        chk("rst_dataa", 32'(core_dataa), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        aclr_n = 1'b1;
        @(negedge clock);

        run_op(32'h3F000000, 1'b0, 0);
        run_op(32'hBE800000, 1'b0, 0);
        run_op(32'h3F800000, 1'b0, 0);
        run_op(32'h7FC00000, 1'b0, 0);
        run_op(32'h33800000, 1'b0, 0);
        run_op(32'h00000000, 1'b0, 0);
        run_op(32'h3F000000, 1'b1, 0);
        run_op(32'h3E800000, 1'b0, 0);
        run_op(32'h3F400000, 1'b0, 10);

        n0 = starts;
        in_valid = 1'b1;
        in_data = 32'h3F000000;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        aclr_n = 1'b0;
        @(negedge clock);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_dataa", 32'(core_dataa), 32'd0);
        aclr_n = 1'b1;
        bad = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (core_start || out_valid) bad = 1'b1;
        end
        chk("mid_rst_quiet", 32'(bad), 32'd0);
        chk("mid_rst_starts", starts - n0, 0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 9))
                0: e = 8'd0;
                1: e = 8'd255;
                2: e = 8'd106;
                3: e = 8'd107;
                default: e = 8'($urandom_range(104, 128));
            endcase
            d = {1'($urandom), e, 23'($urandom)};
            run_op(d, 1'b0, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
